// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point normalization datapath.
package fpu_pkg;
  localparam int unsigned NORM_MANT_WIDTH = 24;
  localparam int unsigned NORM_EXP_WIDTH  = 8;
  localparam int unsigned NUM_NORM_REQ    = 2;

  typedef enum logic {
    REQ_ADDSUB = 1'b0,
    REQ_ITOF   = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [NORM_MANT_WIDTH-1:0] mantissa;
    logic [NORM_EXP_WIDTH-1:0]  exponent;
  } norm_req_t;

  typedef struct packed {
    logic [NORM_MANT_WIDTH-1:0] mantissa;
    logic [NORM_EXP_WIDTH-1:0]  exponent;
    logic                       zero;
  } norm_rsp_t;
endpackage

// File: rtl/normalize_arbiter_if.sv
// Request, normalizer and response signals of the shared normalization unit.
interface normalize_arbiter_if #(
  parameter int unsigned MANT_WIDTH = 24,
  parameter int unsigned EXP_WIDTH  = 8
);
  import fpu_pkg::*;

  logic [NUM_NORM_REQ-1:0]                 req_valid;
  logic [NUM_NORM_REQ-1:0]                 req_ready;
  logic [NUM_NORM_REQ-1:0][MANT_WIDTH-1:0] req_mantissa;
  logic [NUM_NORM_REQ-1:0][EXP_WIDTH-1:0]  req_exponent;

  logic                  nrm_valid;
  logic [MANT_WIDTH-1:0] nrm_mantissa;
  logic [EXP_WIDTH-1:0]  nrm_exponent;
  logic                  nrm_result_valid;
  logic [MANT_WIDTH-1:0] nrm_result_mantissa;
  logic [EXP_WIDTH-1:0]  nrm_result_exponent;
  logic                  nrm_result_zero;

  logic [NUM_NORM_REQ-1:0]                 rsp_valid;
  logic [NUM_NORM_REQ-1:0]                 rsp_ready;
  logic [NUM_NORM_REQ-1:0][MANT_WIDTH-1:0] rsp_mantissa;
  logic [NUM_NORM_REQ-1:0][EXP_WIDTH-1:0]  rsp_exponent;
  logic [NUM_NORM_REQ-1:0]                 rsp_zero;
  logic                                    err_latency;

  modport master (
    output req_valid, req_mantissa, req_exponent,
    output nrm_result_valid, nrm_result_mantissa, nrm_result_exponent, nrm_result_zero,
    output rsp_ready,
    input  req_ready, nrm_valid, nrm_mantissa, nrm_exponent,
    input  rsp_valid, rsp_mantissa, rsp_exponent, rsp_zero, err_latency
  );

  modport slave (
    input  req_valid, req_mantissa, req_exponent,
    input  nrm_result_valid, nrm_result_mantissa, nrm_result_exponent, nrm_result_zero,
    input  rsp_ready,
    output req_ready, nrm_valid, nrm_mantissa, nrm_exponent,
    output rsp_valid, rsp_mantissa, rsp_exponent, rsp_zero, err_latency
  );
endinterface

// File: rtl/norm_result_fifo.sv
// Pointer-based result FIFO; head entry is presented combinationally.
module norm_result_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // Push into a full FIFO overwrites the slot being popped this cycle.
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= push_data;
        wptr_q                <= wptr_q + PTR_ONE;
      end
      if (pop) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/normalize_arbiter.sv
// Round-robin sharing of one fixed-latency normalizer between add/sub and int-to-float,
// with tag-steered returns into credit-protected per-requester result FIFOs.
module normalize_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_WIDTH   = 24,
  parameter int unsigned EXP_WIDTH    = 8,
  parameter int unsigned LATENCY      = 3,
  parameter int unsigned RESULT_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  normalize_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(RESULT_DEPTH) + 1;
  localparam int unsigned RW = MANT_WIDTH + EXP_WIDTH + 1;
  localparam logic [CW-1:0] CREDIT_INIT = CW'(RESULT_DEPTH);

  logic [NUM_NORM_REQ-1:0][CW-1:0] credit_q;
  logic                            last_grant_q;
  logic [LATENCY-1:0]              tag_valid_q;
  logic [LATENCY-1:0]              tag_id_q;
  logic                            err_q;

  logic [NUM_NORM_REQ-1:0]         eligible, grant, push, pop, credit_ret, empty;
  logic [NUM_NORM_REQ-1:0][RW-1:0] head;
  logic                            issue_id, tag_out_valid, tag_out_id;
  logic [RW-1:0]                   result_word;

  always_comb begin
    for (int i = 0; i < NUM_NORM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (credit_q[i] != '0);
    end
    grant = '0;
    if (!reset) begin
      grant[REQ_ADDSUB] = eligible[REQ_ADDSUB] && (!eligible[REQ_ITOF] || last_grant_q == REQ_ITOF);
      grant[REQ_ITOF]   = eligible[REQ_ITOF] && (!eligible[REQ_ADDSUB] || last_grant_q == REQ_ADDSUB);
    end
    issue_id = grant[REQ_ITOF];
  end

  assign bus.req_ready    = grant;
  assign bus.nrm_valid    = |grant;
  assign bus.nrm_mantissa = (|grant) ? bus.req_mantissa[issue_id] : '0;
  assign bus.nrm_exponent = (|grant) ? bus.req_exponent[issue_id] : '0;

  assign tag_out_valid = tag_valid_q[LATENCY-1];
  assign tag_out_id    = tag_id_q[LATENCY-1];
  assign result_word   = {bus.nrm_result_mantissa, bus.nrm_result_exponent, bus.nrm_result_zero};

  always_comb begin
    push       = '0;
    credit_ret = '0;
    pop        = '0;
    for (int i = 0; i < NUM_NORM_REQ; i++) begin
      push[i]       = tag_out_valid && bus.nrm_result_valid && (tag_out_id == 1'(i));
      // A missing result frees the slot it had reserved.
      credit_ret[i] = tag_out_valid && !bus.nrm_result_valid && (tag_out_id == 1'(i));
      pop[i]        = !empty[i] && bus.rsp_ready[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_q     <= {NUM_NORM_REQ{CREDIT_INIT}};
      last_grant_q <= REQ_ITOF;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_NORM_REQ; i++) begin
        credit_q[i] <= credit_q[i] + CW'(pop[i]) + CW'(credit_ret[i]) - CW'(grant[i]);
      end
      if (|grant) last_grant_q <= issue_id;
      tag_valid_q[0] <= |grant;
      tag_id_q[0]    <= issue_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_id_q[s]    <= tag_id_q[s-1];
      end
      if (tag_out_valid != bus.nrm_result_valid) err_q <= 1'b1;
    end
  end

  assign bus.err_latency = err_q;

  for (genvar g = 0; g < NUM_NORM_REQ; g++) begin : g_fifo
    norm_result_fifo #(
      .WIDTH (RW),
      .DEPTH (RESULT_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .push_data (result_word),
      .pop       (pop[g]),
      .head      (head[g]),
      .empty     (empty[g])
    );
    assign bus.rsp_valid[g] = !empty[g];
    assign {bus.rsp_mantissa[g], bus.rsp_exponent[g], bus.rsp_zero[g]} = head[g];
  end
endmodule

// File: tb/tb_normalize_arbiter.sv
// Randomized bench for normalize_arbiter against a queue-based reference model.
module tb_normalize_arbiter;
  import fpu_pkg::*;

  localparam int MW  = 24;
  localparam int EW  = 8;
  localparam int LAT = 3;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  normalize_arbiter_if #(.MANT_WIDTH(MW), .EXP_WIDTH(EW)) bus ();

  normalize_arbiter #(
    .MANT_WIDTH   (MW),
    .EXP_WIDTH    (EW),
    .LATENCY      (LAT),
    .RESULT_DEPTH (DEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int        id;
    int        due;
    norm_rsp_t rsp;
    bit        suppress;
  } op_t;

  op_t       infl[$];
  norm_rsp_t rq[2][$];
  bit        m_err;
  bit        m_last;
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  int        issues[2];
  int        pops[2];

  logic [1:0]    d_valid, d_ready;
  logic [MW-1:0] d_mant[2];
  logic [EW-1:0] d_exp[2];
  bit            d_suppress, d_spurious;

  logic [1:0]    s_req_ready, s_rsp_valid, s_zero;
  logic          s_err;
  logic [MW-1:0] s_mant[2];
  logic [EW-1:0] s_exp[2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endfunction

  // Leading-zero normalization as a plain loop: shift until the MSB is set.
  function automatic norm_rsp_t norm_model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    norm_rsp_t     r;
    logic [MW-1:0] v = m;
    int            lz = 0;
    r.zero = (m == '0);
    if (r.zero) begin
      r.mantissa = '0;
      r.exponent = e;
    end else begin
      for (int k = 0; k < MW; k++) begin
        if (!v[MW-1]) begin
          v = v << 1;
          lz++;
        end
      end
      r.mantissa = v;
      r.exponent = e - EW'(lz);
    end
    return r;
  endfunction

  task automatic idle();
    d_valid    = '0;
    d_ready    = '0;
    d_suppress = 1'b0;
    d_spurious = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      issues[i] = 0;
      pops[i]   = 0;
    end
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    bus.req_valid       = 2'b11;
    bus.rsp_ready       = 2'b11;
    bus.req_mantissa[0] = MW'($urandom) | 24'h1;
    bus.req_mantissa[1] = MW'($urandom) | 24'h1;
    bus.req_exponent[0] = EW'($urandom);
    bus.req_exponent[1] = EW'($urandom);
    bus.nrm_result_valid    = 1'b0;
    bus.nrm_result_mantissa = '0;
    bus.nrm_result_exponent = '0;
    bus.nrm_result_zero     = 1'b0;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_nrm_valid", 64'(bus.nrm_valid), 64'(0));
    chk("rst_nrm_mant", 64'(bus.nrm_mantissa), 64'(0));
    chk("rst_nrm_exp", 64'(bus.nrm_exponent), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_mant", 64'(bus.rsp_mantissa), 64'(0));
    chk("rst_rsp_exp", 64'(bus.rsp_exponent), 64'(0));
    chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'(0));
    chk("rst_err", 64'(bus.err_latency), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    infl.delete();
    rq[0].delete();
    rq[1].delete();
    m_err  = 1'b0;
    m_last = 1'b1;
  endtask

  // One clock: drive, compare against the model at negedge, then advance the model.
  task automatic cycle();
    bit         due_now, spur_now;
    op_t        due_op;
    op_t        o;
    logic [1:0] elig, g, pop;
    logic [MW-1:0] e_mant;
    logic [EW-1:0] e_exp;
    int         cnt, id;
    bit         ev;

    bus.req_valid = d_valid;
    bus.rsp_ready = d_ready;
    for (int i = 0; i < 2; i++) begin
      bus.req_mantissa[i] = d_mant[i];
      bus.req_exponent[i] = d_exp[i];
    end
    due_now  = (infl.size() > 0) && (infl[0].due == cyc);
    if (due_now) due_op = infl[0];
    spur_now = !due_now && d_spurious;
    bus.nrm_result_valid    = (due_now && !due_op.suppress) || spur_now;
    bus.nrm_result_mantissa = '0;
    bus.nrm_result_exponent = '0;
    bus.nrm_result_zero     = 1'b0;
    if (due_now && !due_op.suppress) begin
      bus.nrm_result_mantissa = due_op.rsp.mantissa;
      bus.nrm_result_exponent = due_op.rsp.exponent;
      bus.nrm_result_zero     = due_op.rsp.zero;
    end else if (spur_now) begin
      bus.nrm_result_mantissa = MW'($urandom);
      bus.nrm_result_exponent = EW'($urandom);
    end

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cnt = rq[i].size();
      foreach (infl[k]) if (infl[k].id == i) cnt++;
      elig[i] = d_valid[i] && (cnt < DEP);
    end
    g[0] = elig[0] && (!elig[1] || m_last == 1'b1);
    g[1] = elig[1] && (!elig[0] || m_last == 1'b0);
    e_mant = g[0] ? d_mant[0] : (g[1] ? d_mant[1] : '0);
    e_exp  = g[0] ? d_exp[0] : (g[1] ? d_exp[1] : '0);
    chk("req_ready", 64'(bus.req_ready), 64'(g));
    chk("nrm_valid", 64'(bus.nrm_valid), 64'(|g));
    chk("nrm_mantissa", 64'(bus.nrm_mantissa), 64'(e_mant));
    chk("nrm_exponent", 64'(bus.nrm_exponent), 64'(e_exp));
    chk("err_latency", 64'(bus.err_latency), 64'(m_err));
    for (int i = 0; i < 2; i++) begin
      ev = rq[i].size() > 0;
      chk($sformatf("rsp_valid%0d", i), 64'(bus.rsp_valid[i]), 64'(ev));
      if (ev) begin
        chk($sformatf("rsp_mantissa%0d", i), 64'(bus.rsp_mantissa[i]), 64'(rq[i][0].mantissa));
        chk($sformatf("rsp_exponent%0d", i), 64'(bus.rsp_exponent[i]), 64'(rq[i][0].exponent));
        chk($sformatf("rsp_zero%0d", i), 64'(bus.rsp_zero[i]), 64'(rq[i][0].zero));
      end
      pop[i] = ev && d_ready[i];
      if (bus.req_ready[i]) issues[i]++;
      if (bus.rsp_valid[i] && d_ready[i]) pops[i]++;
      s_mant[i] = bus.rsp_mantissa[i];
      s_exp[i]  = bus.rsp_exponent[i];
    end
    s_req_ready = bus.req_ready;
    s_rsp_valid = bus.rsp_valid;
    s_zero      = bus.rsp_zero;
    s_err       = bus.err_latency;

    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (pop[i]) void'(rq[i].pop_front());
    if (due_now) begin
      void'(infl.pop_front());
      if (due_op.suppress) m_err = 1'b1;
      else rq[due_op.id].push_back(due_op.rsp);
    end else if (spur_now) begin
      m_err = 1'b1;
    end
    if (|g) begin
      id = g[1] ? 1 : 0;
      o.id       = id;
      o.due      = cyc + LAT;
      o.rsp      = norm_model(d_mant[id], d_exp[id]);
      o.suppress = d_suppress;
      infl.push_back(o);
      m_last = g[1];
    end
    cyc++;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 2; i++) begin
      d_mant[i] = '0;
      d_exp[i]  = '0;
    end
    #1;
    do_reset();

    // Idle after reset
    cycle();
    chk("idle_rsp_valid", 64'(s_rsp_valid), 64'(0));
    chk("idle_err", 64'(s_err), 64'(0));

    // Single request, result four cycles after issue
    d_valid = 2'b01; d_mant[0] = 24'h000F00; d_exp[0] = 8'h80; d_mant[1] = 24'h123456;
    cycle();
    chk("single_grant", 64'(s_req_ready), 64'(2'b01));
    idle();
    cycle(); cycle(); cycle();
    chk("single_t3_valid", 64'(s_rsp_valid), 64'(0));
    cycle();
    chk("single_t4_valid", 64'(s_rsp_valid), 64'(2'b01));
    chk("single_t4_mant", 64'(s_mant[0]), 64'(24'hF00000));
    chk("single_t4_exp", 64'(s_exp[0]), 64'(8'h74));

    // Contention alternates starting with requester 0
    do_reset();
    clear_counts();
    d_valid = 2'b11; d_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        d_mant[i] = MW'($urandom);
        d_exp[i]  = EW'($urandom);
      end
      cycle();
      chk($sformatf("contend_grant%0d", k), 64'(s_req_ready), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
    end
    d_valid = 2'b00;
    for (int k = 0; k < 8; k++) cycle();
    chk("contend_pops0", 64'(pops[0]), 64'(4));
    chk("contend_pops1", 64'(pops[1]), 64'(4));

    // Backpressure on requester 1
    do_reset();
    clear_counts();
    d_valid = 2'b11; d_ready = 2'b01;
    for (int k = 0; k < 16; k++) begin
      d_mant[0] = MW'($urandom); d_mant[1] = MW'($urandom);
      cycle();
    end
    chk("bp_issues1", 64'(issues[1]), 64'(4));
    chk("bp_ready1_low", 64'(s_req_ready[1]), 64'(0));
    chk("bp_issues0_more", 64'(issues[0] > 8), 64'(1));
    d_ready = 2'b11;
    cycle();
    d_ready = 2'b01;
    for (int k = 0; k < 8; k++) cycle();
    chk("bp_issues1_after", 64'(issues[1]), 64'(5));

    // Zero operand
    do_reset();
    idle();
    d_valid = 2'b10; d_mant[1] = '0; d_exp[1] = 8'h55;
    cycle();
    idle();
    for (int k = 0; k < 4; k++) cycle();
    chk("zero_valid", 64'(s_rsp_valid), 64'(2'b10));
    chk("zero_flag", 64'(s_zero[1]), 64'(1));

    // Missing result for a tagged issue
    do_reset();
    clear_counts();
    d_valid = 2'b01; d_suppress = 1'b1; d_mant[0] = 24'h00ABCD;
    cycle();
    idle();
    cycle(); cycle(); cycle();
    chk("proto_err_t3", 64'(s_err), 64'(0));
    cycle();
    chk("proto_err_t4", 64'(s_err), 64'(1));
    chk("proto_no_push", 64'(s_rsp_valid), 64'(0));
    clear_counts();
    d_valid = 2'b01;
    for (int k = 0; k < 5; k++) cycle();
    chk("proto_credit_back", 64'(issues[0]), 64'(4));

    // Untagged result pulse
    do_reset();
    idle();
    d_spurious = 1'b1;
    cycle();
    chk("spur_err_same", 64'(s_err), 64'(0));
    d_spurious = 1'b0;
    cycle();
    chk("spur_err_next", 64'(s_err), 64'(1));

    // Reset with work in flight
    do_reset();
    idle();
    d_valid = 2'b01; cycle();
    d_valid = 2'b00; cycle();
    d_valid = 2'b01; cycle();
    d_valid = 2'b10; cycle();
    do_reset();
    clear_counts();
    idle();
    d_valid = 2'b11;
    cycle();
    chk("midrst_grant", 64'(s_req_ready), 64'(2'b01));
    chk("midrst_rsp_valid", 64'(s_rsp_valid), 64'(0));
    chk("midrst_err", 64'(s_err), 64'(0));
    d_valid = 2'b01;
    for (int k = 0; k < 4; k++) cycle();
    chk("midrst_credits", 64'(issues[0]), 64'(4));

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [MW-1:0] t;
      d_valid = 2'($urandom);
      d_ready = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        t         = MW'($urandom);
        d_mant[i] = t >> $urandom_range(0, MW);
        d_exp[i]  = EW'($urandom);
      end
      d_suppress = ($urandom_range(0, 39) == 0);
      d_spurious = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
